// File: rtl/mem_responder_if.sv
// CPU external-memory bus and ROM boot-load port between the 8051 core and mem_responder.
// data_bus is a plain inout on the responder, so only its drive enable is carried here.
interface mem_responder_if #(
   parameter int ROM_AW = 12
);
   logic [15:0]       addr_bus;
   logic              read_en;
   logic              write_en;
   logic              memory_select;
   logic              load_valid;
   logic              load_ready;
   logic [ROM_AW-1:0] load_addr;
   logic [7:0]        load_data;
   logic              load_last;
   logic              boot_done;
   logic [2:0]        err_flags;
   logic              err_clr;
   logic [15:0]       rd_count;
   logic [15:0]       wr_count;
   logic              bus_oe;

   modport master (
      output addr_bus, read_en, write_en, memory_select,
      output load_valid, load_addr, load_data, load_last, err_clr,
      input  load_ready, boot_done, err_flags, rd_count, wr_count, bus_oe
   );

   modport slave (
      input  addr_bus, read_en, write_en, memory_select,
      input  load_valid, load_addr, load_data, load_last, err_clr,
      output load_ready, boot_done, err_flags, rd_count, wr_count, bus_oe
   );
endinterface

// File: rtl/mem_responder.sv
// Bus target for the 8051 external memory bus: 256-byte RAM, boot-loadable ROM,
// zero-latency reads, sticky error flags and saturating access counters.
//
// state | meaning
// BOOT  | reset state; ROM load port open, ROM reads return NOP
// RUN   | image complete after the last load beat; ROM reads return loaded data
module mem_responder #(
   parameter int          ROM_AW   = 12,
   parameter logic [15:0] ROM_BASE = 16'hA000
) (
   input  logic           clk,
   input  logic           reset,
   inout  wire  [7:0]     data_bus,
   mem_responder_if.slave bus
);
   localparam int ROM_DEPTH = 1 << ROM_AW;

   typedef enum logic {BOOT, RUN} state_t;

   state_t      state;
   logic [7:0]  ram [256];
   logic [7:0]  rom [ROM_DEPTH];

   logic        valid_rd;
   logic        rom_rd;
   logic        ram_wr;
   logic        collide;
   logic        load_rdy;
   logic        load_acc;
   logic        in_window;
   logic        drive_en;
   logic [16:0] rom_diff;
   logic [7:0]  rd_data;
   logic [2:0]  err_set;
   logic [2:0]  err_q;
   logic [15:0] rd_cnt;
   logic [15:0] wr_cnt;

   always_comb begin
      valid_rd  = bus.read_en & ~bus.write_en;
      rom_rd    = valid_rd & ~bus.memory_select;
      collide   = bus.read_en & bus.write_en;
      ram_wr    = bus.write_en & ~bus.read_en & bus.memory_select & ~reset;
      // A borrow out of bit 16 means the address sits below ROM_BASE.
      rom_diff  = {1'b0, bus.addr_bus} - {1'b0, ROM_BASE};
      in_window = (rom_diff[16:ROM_AW] == '0);
      // A CPU ROM read owns the array for the cycle, so loads back off.
      load_rdy  = (state == BOOT) & ~reset & ~rom_rd;
      load_acc  = load_rdy & bus.load_valid;
      drive_en  = valid_rd & ~reset;

      rd_data = 8'h00;
      if (bus.memory_select) begin
         rd_data = ram[bus.addr_bus[7:0]];
      end else if (state == RUN && in_window) begin
         rd_data = rom[rom_diff[ROM_AW-1:0]];
      end

      err_set[0] = collide;
      err_set[1] = bus.write_en & ~bus.read_en & ~bus.memory_select;
      err_set[2] = rom_rd & (state == RUN) & ~in_window;
   end

   assign data_bus       = drive_en ? rd_data : 8'bz;
   assign bus.bus_oe     = drive_en;
   assign bus.load_ready = load_rdy;
   assign bus.boot_done  = (state == RUN);
   assign bus.err_flags  = err_q;
   assign bus.rd_count   = rd_cnt;
   assign bus.wr_count   = wr_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= BOOT;
         err_q  <= 3'b000;
         rd_cnt <= 16'h0000;
         wr_cnt <= 16'h0000;
      end else begin
         if (state == BOOT && load_acc && bus.load_last) begin
            state <= RUN;
         end
         // A new error in the clearing cycle survives the clear.
         err_q <= (err_q & {3{~bus.err_clr}}) | err_set;
         if (valid_rd && rd_cnt != 16'hFFFF) begin
            rd_cnt <= rd_cnt + 16'd1;
         end
         if (ram_wr && wr_cnt != 16'hFFFF) begin
            wr_cnt <= wr_cnt + 16'd1;
         end
      end
   end

   // Storage is deliberately outside the reset domain so contents survive reset.
   always_ff @(posedge clk) begin
      if (ram_wr) begin
         ram[bus.addr_bus[7:0]] <= data_bus;
      end
      if (load_acc) begin
         rom[bus.load_addr] <= bus.load_data;
      end
   end
endmodule

// File: tb/tb_mem_responder.sv
// Directed plus randomized bench for mem_responder against a byte-array reference model.
module tb_mem_responder;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] tb_dout = 8'h00;
   logic       tb_drv = 1'b0;
   wire  [7:0] data_bus;

   int checks = 0;
   int errors = 0;

   logic [7:0] ram_m [256];
   bit         ram_k [256];
   logic [7:0] rom_m [4096];
   bit         rom_k [4096];
   bit         booted_m;
   logic [2:0] err_m;
   int         rd_m;
   int         wr_m;

   mem_responder_if #(.ROM_AW(12)) bus ();

   mem_responder #(.ROM_AW(12), .ROM_BASE(16'hA000)) dut (
      .clk      (clk),
      .reset    (reset),
      .data_bus (data_bus),
      .bus      (bus)
   );

   assign data_bus = tb_drv ? tb_dout : 8'bz;

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
         $error("check %s did not match", tag);
      end
   endtask

   task automatic idle_inputs();
      bus.read_en       = 1'b0;
      bus.write_en      = 1'b0;
      bus.memory_select = 1'b0;
      bus.addr_bus      = 16'h0000;
      bus.load_valid    = 1'b0;
      bus.load_addr     = 12'h000;
      bus.load_data     = 8'h00;
      bus.load_last     = 1'b0;
      bus.err_clr       = 1'b0;
      tb_drv            = 1'b0;
      tb_dout           = 8'h00;
   endtask

   task automatic check_regs(input string when);
      chk({when, "_boot_done"}, bus.boot_done, booted_m);
      chk({when, "_err_flags"}, bus.err_flags, err_m);
      chk({when, "_rd_count"},  bus.rd_count,  rd_m[15:0]);
      chk({when, "_wr_count"},  bus.wr_count,  wr_m[15:0]);
   endtask

   // Reset with a read strobe and a load beat pending: nothing may respond.
   task automatic apply_reset();
      reset             = 1'b1;
      bus.read_en       = 1'b1;
      bus.memory_select = 1'b1;
      bus.load_valid    = 1'b1;
      booted_m = 1'b0;
      err_m    = 3'b000;
      rd_m     = 0;
      wr_m     = 0;
      #3;
      chk("rst_load_ready", bus.load_ready, 1'b0);
      chk("rst_bus_oe",     bus.bus_oe,     1'b0);
      check_regs("rst");
      @(posedge clk);
      #1;
      reset = 1'b0;
      idle_inputs();
   endtask

   // One bus cycle starting just after a rising edge.
   task automatic do_cycle(input bit re, input bit we, input bit ms, input logic [15:0] addr,
                           input logic [7:0] wd, input bit lv, input logic [11:0] la,
                           input logic [7:0] ld, input bit ll, input bit clr, input bit chk_on);
      int         a;
      int         off;
      bit         vrd;
      bit         inwin;
      bit         ready_e;
      bit         known;
      logic [7:0] exp_d;
      logic [2:0] set;
      bus.read_en       = re;
      bus.write_en      = we;
      bus.memory_select = ms;
      bus.addr_bus      = addr;
      bus.load_valid    = lv;
      bus.load_addr     = la;
      bus.load_data     = ld;
      bus.load_last     = ll;
      bus.err_clr       = clr;
      tb_drv            = we;
      tb_dout           = wd;
      #3;
      a       = int'(addr);
      off     = a - 'hA000;
      inwin   = (a >= 'hA000) && (a < 'hA000 + 4096);
      vrd     = re && !we;
      ready_e = !booted_m && !(vrd && !ms);
      known   = 1'b1;
      exp_d   = 8'h00;
      if (ms) begin
         exp_d = ram_m[a % 256];
         known = ram_k[a % 256];
      end else if (booted_m && inwin) begin
         exp_d = rom_m[off];
         known = rom_k[off];
      end
      if (chk_on) begin
         chk("bus_oe",     bus.bus_oe,     vrd);
         chk("load_ready", bus.load_ready, ready_e);
         if (vrd && known) chk("read_data", data_bus, exp_d);
      end
      set   = {vrd && !ms && booted_m && !inwin, we && !re && !ms, re && we};
      err_m = (clr ? 3'b000 : err_m) | set;
      if (vrd && rd_m < 65535) rd_m++;
      if (we && !re && ms) begin
         ram_m[a % 256] = wd;
         ram_k[a % 256] = 1'b1;
         if (wr_m < 65535) wr_m++;
      end
      if (lv && ready_e) begin
         rom_m[la] = ld;
         rom_k[la] = 1'b1;
         if (ll) booted_m = 1'b1;
      end
      @(posedge clk);
      #1;
      idle_inputs();
      if (chk_on) check_regs("post");
   endtask

   task automatic rd(input bit ms, input logic [15:0] addr);
      do_cycle(1, 0, ms, addr, 8'h00, 0, 12'h000, 8'h00, 0, 0, 1);
   endtask

   task automatic wr(input bit ms, input logic [15:0] addr, input logic [7:0] d);
      do_cycle(0, 1, ms, addr, d, 0, 12'h000, 8'h00, 0, 0, 1);
   endtask

   task automatic load(input logic [11:0] la, input logic [7:0] ld, input bit ll);
      do_cycle(0, 0, 0, 16'h0000, 8'h00, 1, la, ld, ll, 0, 1);
   endtask

   initial begin
      logic [15:0] ra;
      int          pick;
      idle_inputs();
      apply_reset();

      // BOOT: NOP reads, and a concurrent ROM read blocks the load beat
      do_cycle(1, 0, 0, 16'hA845, 8'h00, 1, 12'h845, 8'h74, 0, 0, 1);
      load(12'h845, 8'h74, 0);
      load(12'h000, 8'h3C, 0);
      load(12'hFFF, 8'hC3, 0);
      rd(0, 16'hA000);
      load(12'h846, 8'h55, 1);
      load(12'h123, 8'hEE, 0);

      // RUN: fetch, window edges, out-of-range reads
      rd(0, 16'hA845);
      rd(0, 16'hA846);
      rd(0, 16'hA000);
      rd(0, 16'hAFFF);
      rd(0, 16'h9FFF);
      do_cycle(0, 0, 0, 16'h0000, 8'h00, 0, 12'h000, 8'h00, 0, 1, 1);
      rd(0, 16'hB000);
      do_cycle(0, 0, 0, 16'h0000, 8'h00, 0, 12'h000, 8'h00, 0, 1, 1);

      // RAM write/read, aliasing, ROM write attempt
      wr(1, 16'h0030, 8'h55);
      rd(1, 16'h0030);
      wr(1, 16'h1230, 8'hAA);
      rd(1, 16'h0030);
      wr(0, 16'h0030, 8'h11);
      rd(1, 16'h0030);

      // Collision, clear, clear racing a new collision
      do_cycle(1, 1, 1, 16'h0030, 8'h77, 0, 12'h000, 8'h00, 0, 0, 1);
      rd(1, 16'h0030);
      do_cycle(0, 0, 0, 16'h0000, 8'h00, 0, 12'h000, 8'h00, 0, 1, 1);
      do_cycle(1, 1, 0, 16'h0030, 8'h66, 0, 12'h000, 8'h00, 0, 0, 1);
      do_cycle(1, 1, 1, 16'h0031, 8'h66, 0, 12'h000, 8'h00, 0, 1, 1);

      // Randomized traffic in RUN
      for (int i = 0; i < 400; i++) begin
         pick = int'($urandom_range(0, 4));
         case (pick)
            0:       ra = 16'hA000 + 16'($urandom_range(0, 4095));
            1:       ra = 16'h9FF0 + 16'($urandom_range(0, 15));
            2:       ra = 16'hB000 + 16'($urandom_range(0, 15));
            3:       ra = 16'hA845;
            default: ra = 16'($urandom_range(0, 65535));
         endcase
         do_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)), ra,
                  8'($urandom), 1'($urandom_range(0, 1)), 12'($urandom), 8'($urandom), 1'b0,
                  $urandom_range(0, 7) == 0, 1);
      end

      // Reset mid-load keeps partial contents; reload only the last beat
      apply_reset();
      load(12'h100, 8'h5A, 0);
      load(12'h101, 8'hA5, 0);
      bus.load_valid = 1'b1;
      bus.load_addr  = 12'h102;
      bus.load_data  = 8'h99;
      apply_reset();
      rd(0, 16'hA845);
      load(12'h846, 8'h99, 1);
      rd(0, 16'hA845);
      rd(0, 16'hA100);
      rd(0, 16'hA101);
      rd(0, 16'hA846);
      rd(0, 16'hA000);

      // Read counter saturation
      wr(1, 16'h0010, 8'h42);
      for (int i = 0; i < 65540; i++) begin
         do_cycle(1, 0, 1, 16'h0010, 8'h00, 0, 12'h000, 8'h00, 0, 0, 0);
      end
      rd(1, 16'h0010);
      chk("rd_count_sat", bus.rd_count, 16'hFFFF);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
